// File: rtl/mcpu_dram_ctrl.sv
// mcpu_dram_ctrl: handshaked data-RAM controller for the MCPU.
// A synchronous-read word array sits behind a req/ack interface. The
// controller adds programmable wait states and byte-lane write enables,
// and can optionally zero-fill the whole array after reset.
//
// Ports:
//   clk      system clock, rising-edge active
//   reset    synchronous active-high reset
//   req      access request, sampled only while idle
//   we       1 = write, 0 = read (captured with req)
//   addr     word address (captured with req)
//   data_in  write data (captured with req)
//   be       byte enables, be[i] gates bits [8i+7:8i] (captured with req)
//   data_out registered read data, holds the last read value
//   ack      one-cycle completion pulse
//   busy     high while the post-reset zero-fill runs
module mcpu_dram_ctrl #(
  parameter int unsigned DRAM_DATA_BITS = 16,
  parameter int unsigned DRAM_ADDR_BITS = 14,
  parameter int unsigned WAIT_STATES    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic                        we,
  input  logic [DRAM_ADDR_BITS-1:0]   addr,
  input  logic [DRAM_DATA_BITS-1:0]   data_in,
  input  logic [DRAM_DATA_BITS/8-1:0] be,
  output logic [DRAM_DATA_BITS-1:0]   data_out,
  output logic                        ack,
  output logic                        busy
);

  localparam int unsigned BE_BITS   = DRAM_DATA_BITS / 8;
  localparam int unsigned DEPTH     = 2 ** DRAM_ADDR_BITS;
  localparam int unsigned WAIT_BITS = 4;
  localparam logic [WAIT_BITS-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? WAIT_BITS'(WAIT_STATES - 1) : '0;
  localparam logic [DRAM_ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t                      state_q, state_d;
  logic [DRAM_ADDR_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WAIT_BITS-1:0]        wait_cnt_q, wait_cnt_d;
  logic                        we_q, we_d;
  logic [DRAM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DRAM_DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [BE_BITS-1:0]          be_q, be_d;
  logic                        ack_d;
  logic                        busy_d;

  // Single RAM port, shared between zero-fill and normal accesses
  logic                        mem_wr_c;
  logic [DRAM_ADDR_BITS-1:0]   mem_addr_c;
  logic [DRAM_DATA_BITS-1:0]   mem_wdata_c;
  logic [BE_BITS-1:0]          mem_be_c;
  logic                        rd_en_c;

  logic [DRAM_DATA_BITS-1:0]   mem [DEPTH];

  // Next-state, request capture and RAM port control
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    ack_d       = 1'b0;
    busy_d      = busy;
    mem_wr_c    = 1'b0;
    mem_addr_c  = addr_q;
    mem_wdata_c = wdata_q;
    mem_be_c    = be_q;
    rd_en_c     = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        mem_wr_c    = 1'b1;
        mem_addr_c  = clr_cnt_q;
        mem_wdata_c = '0;
        mem_be_c    = '1;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = data_in;
          be_d    = be;
          if (WAIT_STATES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_ACCESS: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (we_q) begin
          mem_wr_c = 1'b1;
        end else begin
          rd_en_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset abandons whatever the RAM port was about to do
    if (reset) begin
      mem_wr_c = 1'b0;
      rd_en_c  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DO_CLEAR ? S_CLEAR : S_IDLE;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ack        <= 1'b0;
      busy       <= DO_CLEAR;
      data_out   <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ack        <= ack_d;
      busy       <= busy_d;
      if (rd_en_c) begin
        data_out <= mem[addr_q];
      end
    end
  end

  // Byte-lane RAM write; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      for (int i = 0; i < BE_BITS; i++) begin
        if (mem_be_c[i]) begin
          mem[mem_addr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mcpu_dram_ctrl.sv
// Bench for mcpu_dram_ctrl: two instances (3 wait states with zero-fill,
// 0 wait states without) checked against a word-array reference model.
module tb_mcpu_dram_ctrl;

  localparam int unsigned AB = 4;
  localparam int unsigned DB = 16;
  localparam int unsigned NW = 16;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        req  [2];
  logic        we   [2];
  logic [AB-1:0] addr [2];
  logic [DB-1:0] din  [2];
  logic [1:0]  be   [2];
  logic [DB-1:0] dout [2];
  logic        ack  [2];
  logic        busy [2];

  logic [DB-1:0] model   [2][NW];
  logic [DB-1:0] last_rd [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mcpu_dram_ctrl #(
    .DRAM_DATA_BITS(DB), .DRAM_ADDR_BITS(AB), .WAIT_STATES(3), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .data_in(din[0]), .be(be[0]), .data_out(dout[0]), .ack(ack[0]), .busy(busy[0])
  );

  mcpu_dram_ctrl #(
    .DRAM_DATA_BITS(DB), .DRAM_ADDR_BITS(AB), .WAIT_STATES(0), .CLEAR_ON_RESET(0)
  ) dut1 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .data_in(din[1]), .be(be[1]), .data_out(dout[1]), .ack(ack[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic bit clr_of(input int k);
    return (k == 0);
  endfunction

  function automatic logic [DB-1:0] merge(input logic [DB-1:0] old_w,
                                          input logic [DB-1:0] new_w,
                                          input logic [1:0] b);
    logic [DB-1:0] mask;
    mask = {{8{b[1]}}, {8{b[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One handshaked access; checks latency, data and ack width
  task automatic access(input int k, input bit w, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, input logic [1:0] b);
    int lat;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; din[k] = d; be[k] = b;
    @(posedge clk);
    @(negedge clk);
    req[k]  = 1'b0;
    we[k]   = 1'($urandom);
    addr[k] = AB'($urandom);
    din[k]  = DB'($urandom);
    be[k]   = 2'($urandom);
    lat = 0;
    while (ack[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ack_latency", lat, ws_of(k) + 1);
    if (w) begin
      model[k][a] = merge(model[k][a], d, b);
      check("write_keeps_dout", dout[k], last_rd[k]);
    end else begin
      last_rd[k] = model[k][a];
      check("read_data", dout[k], model[k][a]);
    end
    @(negedge clk);
    check("ack_width", ack[k], 1'b0);
  endtask

  // Called on the negedge where reset falls; counts busy cycles
  task automatic busy_check(input int k, input bit poke);
    int cnt;
    bit saw_ack;
    cnt = 0;
    saw_ack = 1'b0;
    if (poke) begin
      req[k] = 1'b1; we[k] = 1'b1; addr[k] = 4'd2; din[k] = 16'hFFFF; be[k] = 2'b11;
    end
    while (busy[k] === 1'b1 && cnt < 40) begin
      if (ack[k] === 1'b1) saw_ack = 1'b1;
      cnt++;
      @(negedge clk);
    end
    if (ack[k] === 1'b1) saw_ack = 1'b1;
    req[k] = 1'b0;
    check("busy_cycles", cnt, clr_of(k) ? NW : 0);
    check("no_ack_while_busy", saw_ack, 1'b0);
  endtask

  task automatic apply_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b1;
    repeat (2) @(negedge clk);
    rst[k] = 1'b0;
  endtask

  task automatic model_reset(input int k);
    last_rd[k] = '0;
    if (clr_of(k)) begin
      for (int i = 0; i < NW; i++) model[k][i] = '0;
    end
  endtask

  // Reads/write/read with req held high the whole time
  task automatic back_to_back(input int k);
    int tack [3];
    int lat;
    access(k, 1'b1, 4'd1, 16'h1357, 2'b11);
    @(negedge clk);
    req[k] = 1'b1; we[k] = 1'b0; addr[k] = 4'd1; din[k] = '0; be[k] = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      while (ack[k] !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("b2b_ack_seen", ack[k], 1'b1);
      tack[i] = cyc;
      if (i == 1) begin
        model[k][1] = 16'hCAFE;
        check("b2b_dout_held", dout[k], 16'h1357);
      end else begin
        last_rd[k] = model[k][1];
        check("b2b_read", dout[k], (i == 0) ? 16'h1357 : 16'hCAFE);
      end
      if (i == 0) begin
        we[k] = 1'b1; din[k] = 16'hCAFE;
      end else if (i == 1) begin
        we[k] = 1'b0; din[k] = 16'h0000;
      end else begin
        req[k] = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_spacing_1", tack[1] - tack[0], ws_of(k) + 2);
    check("b2b_spacing_2", tack[2] - tack[1], ws_of(k) + 2);
  endtask

  initial begin
    int acks_seen;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; din[k] = '0; be[k] = '0;
      last_rd[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("reset_dout", dout[k], 16'h0000);
      check("reset_ack", ack[k], 1'b0);
      check("reset_busy", busy[k], clr_of(k));
      model_reset(k);
    end
    busy_check(0, 1'b1);
    busy_check(1, 1'b0);

    for (int k = 0; k < 2; k++) begin
      if (clr_of(k)) begin
        for (int a = 0; a < NW; a++) access(k, 1'b0, AB'(a), '0, 2'b11);
      end else begin
        for (int a = 0; a < NW; a++) access(k, 1'b1, AB'(a), DB'($urandom), 2'b11);
      end

      // Latency and byte lanes on address 3
      access(k, 1'b1, 4'd3, 16'hBEEF, 2'b11);
      access(k, 1'b0, 4'd3, '0, 2'b11);
      check("beef", dout[k], 16'hBEEF);
      access(k, 1'b1, 4'd3, 16'h1234, 2'b01);
      access(k, 1'b0, 4'd3, '0, 2'b11);
      check("lane0", dout[k], 16'hBE34);
      access(k, 1'b1, 4'd3, 16'hAA00, 2'b10);
      access(k, 1'b0, 4'd3, '0, 2'b11);
      check("lane1", dout[k], 16'hAA34);
      access(k, 1'b1, 4'd3, 16'hFFFF, 2'b00);
      access(k, 1'b0, 4'd3, '0, 2'b11);
      check("no_lanes", dout[k], 16'hAA34);

      back_to_back(k);

      for (int n = 0; n < 30; n++) begin
        access(k, 1'($urandom_range(0, 1)), AB'($urandom_range(0, NW - 1)),
               DB'($urandom), 2'($urandom_range(0, 3)));
      end

      // Reset while a write to address 7 is pending
      access(k, 1'b1, 4'd7, 16'h1111, 2'b11);
      @(negedge clk);
      req[k] = 1'b1; we[k] = 1'b1; addr[k] = 4'd7; din[k] = 16'h5555; be[k] = 2'b11;
      @(posedge clk);
      @(negedge clk);
      req[k] = 1'b0;
      rst[k] = 1'b1;
      acks_seen = (ack[k] === 1'b1) ? 1 : 0;
      repeat (2) begin
        @(negedge clk);
        if (ack[k] === 1'b1) acks_seen++;
      end
      rst[k] = 1'b0;
      model_reset(k);
      check("midreset_dout", dout[k], 16'h0000);
      busy_check(k, 1'b0);
      repeat (8) begin
        if (ack[k] === 1'b1) acks_seen++;
        @(negedge clk);
      end
      check("midreset_no_ack", acks_seen, 0);
      access(k, 1'b0, 4'd7, '0, 2'b11);
      check("midreset_word7", dout[k], clr_of(k) ? 16'h0000 : 16'h1111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
